gamecontrol_multi: RTL

Parametrised game controller for the Morse number game, generalising the fixed three-timer hard-mode controller. It draws a sequence of 1..NUM_DIGITS pseudo-random decimal digits per round and shows each for DISPLAY_CYCLES. It then accepts the player's digits one at a time and keeps a two-digit BCD score across MAX_ROUNDS rounds. It sits between the login block and the Morse display/scoreboard, replacing the per-difficulty controllers.

---
 rtl/gamecontrol_pkg.sv | 21 ++
 rtl/morse_lfsr.sv | 18 +
 rtl/gamecontrol_multi.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/gamecontrol_pkg.sv
// Shared definitions for the Morse number-game controller: state encoding,
// BCD digit width and the 4-bit to decimal digit fold.
package gamecontrol_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_GEN,
    ST_SHOW,
    ST_GUESS,
    ST_DONE
  } state_t;

  // Maps a raw nibble onto 0..9 (10..15 become 4..9).
  function automatic logic [BCD_W-1:0] fold_digit(input logic [BCD_W-1:0] raw);
    return (raw >= BCD_W'(10)) ? raw - BCD_W'(6) : raw;
  endfunction

endpackage

// File: rtl/morse_lfsr.sv
// Free-running 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) used as the digit source.
module morse_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SEED;
    end else begin
      q <= {1'b0, q[7:1]} ^ (q[0] ? 8'hB8 : 8'h00);
    end
  end

endmodule

// File: rtl/gamecontrol_multi.sv
// Morse number-game controller: generates 1..NUM_DIGITS digits per round,
// shows each for DISPLAY_CYCLES, then checks the player's guesses and keeps a BCD score.
module gamecontrol_multi
  import gamecontrol_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 3,
  parameter int unsigned DISPLAY_CYCLES = 150000000,
  parameter int unsigned MAX_ROUNDS     = 10,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             logged_in,
  input  logic             game_start,
  input  logic [1:0]       level,
  input  logic             load,
  input  logic [BCD_W-1:0] user_input,
  input  logic             timeout,
  input  logic             logout,
  output logic             reconfig,
  output logic             enable,
  output logic [BCD_W-1:0] number,
  output logic [BCD_W-1:0] score_ones,
  output logic [BCD_W-1:0] score_tens,
  output logic             correct,
  output logic             logout_game
);

  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W   = (DISPLAY_CYCLES > 1) ? $clog2(DISPLAY_CYCLES) : 1;
  localparam int unsigned RND_W   = 7;
  localparam int unsigned MAX_IDX = NUM_DIGITS - 1;

  state_t             state_q, state_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic [IDX_W-1:0]   last_q, last_n, last_sel;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [RND_W-1:0]   round_q, round_n;
  logic [BCD_W-1:0]   buf_q [NUM_DIGITS];
  logic [BCD_W-1:0]   buf_n [NUM_DIGITS];
  logic [BCD_W-1:0]   ones_n, tens_n, number_n;
  logic               reconfig_n, enable_n, correct_n, logout_game_n;
  logic               won, lost, leave;
  logic [7:0]         lfsr_q;
  logic [BCD_W-1:0]   digit;
  logic               unused_lfsr;

  morse_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign digit       = fold_digit(lfsr_q[3:0]);
  assign unused_lfsr = ^lfsr_q[7:4];

  // Last buffer index of the round: min(level+1, NUM_DIGITS) - 1.
  always_comb begin
    if (32'(level) >= MAX_IDX) begin
      last_sel = IDX_W'(MAX_IDX);
    end else begin
      last_sel = IDX_W'(level);
    end
  end

  assign leave = (state_q != ST_IDLE) && (logout || !logged_in);

  // Next-state, datapath and next-output logic; outputs follow the next state.
  always_comb begin
    state_n       = state_q;
    idx_n         = idx_q;
    last_n        = last_q;
    cnt_n         = cnt_q;
    round_n       = round_q;
    buf_n         = buf_q;
    ones_n        = score_ones;
    tens_n        = score_tens;
    won           = 1'b0;
    lost          = 1'b0;
    correct_n     = 1'b0;
    logout_game_n = 1'b0;

    if (leave) begin
      state_n       = ST_IDLE;
      logout_game_n = 1'b1;
      ones_n        = '0;
      tens_n        = '0;
      round_n       = '0;
      idx_n         = '0;
      cnt_n         = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (logged_in) begin
            state_n = ST_WAIT_START;
            ones_n  = '0;
            tens_n  = '0;
            round_n = '0;
          end
        end
        ST_WAIT_START: begin
          if (game_start) begin
            state_n = ST_GEN;
            last_n  = last_sel;
            idx_n   = '0;
          end
        end
        ST_GEN: begin
          buf_n[idx_q] = digit;
          if (idx_q == last_q) begin
            state_n = ST_SHOW;
            idx_n   = '0;
            cnt_n   = '0;
          end else begin
            idx_n = idx_q + IDX_W'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_q == CNT_W'(DISPLAY_CYCLES - 1)) begin
            cnt_n = '0;
            if (idx_q == last_q) begin
              state_n = ST_GUESS;
              idx_n   = '0;
            end else begin
              idx_n = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
        ST_GUESS: begin
          // A load in the same cycle as timeout takes precedence.
          if (load) begin
            if (user_input != buf_q[idx_q]) begin
              lost = 1'b1;
            end else if (idx_q == last_q) begin
              won = 1'b1;
            end else begin
              idx_n = idx_q + IDX_W'(1);
            end
          end else if (timeout) begin
            lost = 1'b1;
          end
          if (won || lost) begin
            idx_n     = '0;
            round_n   = round_q + RND_W'(1);
            correct_n = won;
            state_n   = (round_n >= RND_W'(MAX_ROUNDS)) ? ST_DONE : ST_WAIT_START;
          end
          // BCD increment, saturating at 99.
          if (won) begin
            if (score_ones == BCD_W'(9)) begin
              if (score_tens != BCD_W'(9)) begin
                ones_n = '0;
                tens_n = score_tens + BCD_W'(1);
              end
            end else begin
              ones_n = score_ones + BCD_W'(1);
            end
          end
        end
        ST_DONE: begin
          state_n = ST_DONE;
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end

    enable_n   = (state_n == ST_SHOW);
    number_n   = enable_n ? buf_n[idx_n] : '0;
    reconfig_n = enable_n && (cnt_n == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      cnt_q       <= '0;
      round_q     <= '0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        buf_q[i] <= '0;
      end
      reconfig    <= 1'b0;
      enable      <= 1'b0;
      number      <= '0;
      score_ones  <= '0;
      score_tens  <= '0;
      correct     <= 1'b0;
      logout_game <= 1'b0;
    end else begin
      state_q     <= state_n;
      idx_q       <= idx_n;
      last_q      <= last_n;
      cnt_q       <= cnt_n;
      round_q     <= round_n;
      buf_q       <= buf_n;
      reconfig    <= reconfig_n;
      enable      <= enable_n;
      number      <= number_n;
      score_ones  <= ones_n;
      score_tens  <= tens_n;
      correct     <= correct_n;
      logout_game <= logout_game_n;
    end
  end

endmodule
